pipeline_exec_ctrl: RTL and testbench
=====================================

Name: pipeline_exec_ctrl

Overview:
Execution sequencer for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Gates pipeline advance with a global enable, which covers PC and all stage registers.
- Supports continuous run, single-step, stop and clear.
- Detects the HALT opcode in IF, inserts bubbles until in-flight instructions retire, then parks.
- Sits between the debug/command front end and the pipeline top; counts executed cycles.

Parameters:
CNT_W, 32, cycle counter width
HALT_OPCODE, 32'hFFFF_FFFF, instruction word treated as HALT
DRAIN_CYCLES, 4, bubble cycles after HALT fetch (ID..WB depth)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command strobe
cmd  in  2  00 RUN, 01 STEP, 10 STOP, 11 CLEAR
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
instruction_IF  in  32  instruction currently fetched
pc_IF  in  32  current PC (breakpoint only)
pipe_en  out  1  advance PC + all pipeline registers this cycle
pc_hold  out  1  PC must not update even if pipe_en
fetch_bubble  out  1  IF/ID loads NOP instead of instruction_IF
pipe_flush  out  1  synchronous clear of PC and pipeline registers
busy  out  1  state is RUN, STEP, DRAIN or FLUSH
halted  out  1  state is HALTED
done_pulse  out  1  one-cycle pulse on DRAIN->HALTED
cycle_count  out  CNT_W  cycles with pipe_en=1, saturating

Behaviour:
- Reset (reset=0, async): state IDLE, cycle_count=0, every output 0 except cmd_ready=1.
- States: IDLE, RUN, STEP, DRAIN, HALTED, FLUSH. State is registered; pipe_en, pc_hold and fetch_bubble are decoded from state plus the current-cycle HALT compare.
- cmd_ready=1 in IDLE, RUN and HALTED; 0 in STEP, DRAIN and FLUSH.
- IDLE: pipe_en=0.
  - RUN -> RUN.
  - STEP -> STEP.
  - CLEAR -> FLUSH.
  - STOP is accepted and ignored.
- RUN: pipe_en=1.
  - STOP -> IDLE next cycle; the pipeline freezes mid-flight and is resumable.
  - RUN and STEP are accepted and ignored.
  - CLEAR -> FLUSH.
- STEP: exactly one cycle with pipe_en=1, then IDLE.
- HALT detect: in RUN or STEP, if instruction_IF==HALT_OPCODE then fetch_bubble=1 and pc_hold=1 in that same cycle, and next state is DRAIN.
  - HALT detect beats STOP or CLEAR presented in the same cycle; that command is consumed and dropped.
- DRAIN: pipe_en=1, fetch_bubble=1, pc_hold=1 for DRAIN_CYCLES cycles (internal down-counter), then HALTED with done_pulse=1 on the first HALTED cycle.
- HALTED: pipe_en=0.
  - CLEAR -> FLUSH.
  - All other commands are accepted and ignored.
- FLUSH: one cycle, pipe_flush=1, pipe_en=0; cycle_count cleared to 0; next state IDLE.
- cycle_count increments on every cycle with pipe_en=1, DRAIN included, and holds at all-ones.
- Reset asserted mid-DRAIN or mid-STEP: immediate return to reset values. No drain completion and no done_pulse.

Optional Feature:
PIPE_CTRL_BREAKPOINT_EN
- Defined: adds ports bp_valid (in 1), bp_pc (in 32) and bp_hit (out 1).
  - In RUN, if bp_valid && pc_IF==bp_pc then pipe_en=0 that same cycle, next state IDLE, and bp_hit is set sticky.
  - bp_hit clears on the next accepted command.
  - A following RUN or STEP executes the breakpointed instruction: the compare is masked for the first enabled cycle after IDLE.
- Undefined: no such ports; pc_IF is unused.

Decomposition:
- Shared package/include pipe_ctrl_pkg holds:
  - state encodings (3-bit)
  - cmd codes CMD_RUN, CMD_STEP, CMD_STOP, CMD_CLEAR
  - default HALT_OPCODE
- One sub-module: sat_counter (width-parameterised, enable, sync clear, saturating), used for cycle_count.

Test Plan:
- Reset release, then RUN with program "addi, addi, HALT at pc=8": HALT is seen at cycle 3 -> fetch_bubble=1 for 5 cycles, done_pulse once, halted=1, cycle_count=7.
- STEP x3 from IDLE: exactly 3 single-cycle pipe_en pulses, cmd_ready low on each STEP cycle, cycle_count=3.
- RUN, then STOP at cycle 5, then RUN: pipe_en low exactly 1+ cycles between, no flush, cycle_count continues from 5.
- STOP issued in the same cycle instruction_IF=32'hFFFF_FFFF: DRAIN entered, STOP ignored, halted reached after 4 drain cycles.
- In HALTED, CLEAR: pipe_flush=1 for one cycle, cycle_count=0, state IDLE; RUN/STEP in HALTED leave pipe_en=0.
- reset asserted in DRAIN cycle 2: all outputs return to reset values asynchronously, no done_pulse; with PIPE_CTRL_BREAKPOINT_EN and bp_pc=12, RUN stops with pc_IF=12, bp_hit=1.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline execution sequencer:
//   - 3-bit FSM state encodings (plain localparams so legacy code can reuse them)
//   - debug front-end command codes
//   - default HALT instruction word
//   - helper deciding which states accept a command
// ----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RUN    = 3'd1;
    localparam logic [2:0] ST_STEP   = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_HALTED = 3'd4;
    localparam logic [2:0] ST_FLUSH  = 3'd5;

    localparam logic [1:0] CMD_RUN   = 2'b00;
    localparam logic [1:0] CMD_STEP  = 2'b01;
    localparam logic [1:0] CMD_STOP  = 2'b10;
    localparam logic [1:0] CMD_CLEAR = 2'b11;

    localparam logic [31:0] DEFAULT_HALT_OPCODE = 32'hFFFF_FFFF;

    // Commands are only taken in the "stable" states; STEP, DRAIN and FLUSH
    // are short fixed sequences that must run to completion.
    function automatic logic state_accepts_cmd(input state_t s);
        return (s == ST_IDLE) || (s == ST_RUN) || (s == ST_HALTED);
    endfunction

endpackage

// File: rtl/pipeline_exec_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipeline_exec_ctrl_if
// Bundles the command handshake, fetch-stage observation and pipeline control
// signals of the execution sequencer.
//   master : debug front end / pipeline side (drives cmd, instruction_IF, pc_IF)
//   slave  : the sequencer (drives cmd_ready, pipe_en, pc_hold, fetch_bubble,
//            pipe_flush, busy, halted, done_pulse, cycle_count)
// Optional macro PIPE_CTRL_BREAKPOINT_EN adds bp_valid, bp_pc (to the
// sequencer) and bp_hit (from the sequencer).
// ----------------------------------------------------------------------------
interface pipeline_exec_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             cmd_valid;
    logic [1:0]       cmd;
    logic             cmd_ready;
    logic [31:0]      instruction_IF;
    logic [31:0]      pc_IF;
    logic             pipe_en;
    logic             pc_hold;
    logic             fetch_bubble;
    logic             pipe_flush;
    logic             busy;
    logic             halted;
    logic             done_pulse;
    logic [CNT_W-1:0] cycle_count;
`ifdef PIPE_CTRL_BREAKPOINT_EN
    logic             bp_valid;
    logic [31:0]      bp_pc;
    logic             bp_hit;
`endif

    modport master (
`ifdef PIPE_CTRL_BREAKPOINT_EN
        output bp_valid, bp_pc,
        input  bp_hit,
`endif
        output cmd_valid, cmd, instruction_IF, pc_IF,
        input  cmd_ready, pipe_en, pc_hold, fetch_bubble, pipe_flush,
        input  busy, halted, done_pulse, cycle_count
    );

    modport slave (
`ifdef PIPE_CTRL_BREAKPOINT_EN
        input  bp_valid, bp_pc,
        output bp_hit,
`endif
        input  cmd_valid, cmd, instruction_IF, pc_IF,
        output cmd_ready, pipe_en, pc_hold, fetch_bubble, pipe_flush,
        output busy, halted, done_pulse, cycle_count
    );
endinterface

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Width-parameterised up-counter that sticks at all-ones.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset (count -> 0)
//   clr   : synchronous clear, wins over en
//   en    : count this cycle
//   count : current value
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && (count_reg != {WIDTH{1'b1}})) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;
endmodule

// File: rtl/pipeline_exec_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_exec_ctrl
// Execution sequencer for a 5-stage IF/ID/EX/MEM/WB pipeline. Gates pipeline
// advance (pipe_en), handles RUN / STEP / STOP / CLEAR commands, detects the
// HALT word in IF, drains the in-flight instructions with bubbles, parks in
// HALTED and counts enabled cycles.
//   clk    : system clock, rising edge
//   reset  : asynchronous active-low reset
//   bus    : pipeline_exec_ctrl_if.slave (command handshake, IF observation,
//            pipe_en / pc_hold / fetch_bubble / pipe_flush, status, counter)
// Parameters: CNT_W (counter width), HALT_OPCODE, DRAIN_CYCLES (>= 1).
// Optional macro PIPE_CTRL_BREAKPOINT_EN: PC breakpoint in RUN with sticky
// bp_hit; without it pc_IF is ignored.
// ----------------------------------------------------------------------------
module pipeline_exec_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int          CNT_W        = 32,
    parameter logic [31:0] HALT_OPCODE  = DEFAULT_HALT_OPCODE,
    parameter int          DRAIN_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    pipeline_exec_ctrl_if.slave bus
);
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

    state_t             state_reg;
    state_t             state_next;
    logic [DRAIN_W-1:0] drain_cnt_reg;
    logic [DRAIN_W-1:0] drain_cnt_next;
    logic               done_pulse_reg;

    logic cmd_ready_int;
    logic cmd_accept;
    logic run_like;
    logic bp_stop;
    logic halt_hit;
    logic pipe_en_int;
    logic [CNT_W-1:0] count_int;

    assign cmd_ready_int = state_accepts_cmd(state_reg);
    assign cmd_accept    = bus.cmd_valid && cmd_ready_int;
    assign run_like      = (state_reg == ST_RUN) || (state_reg == ST_STEP);

`ifdef PIPE_CTRL_BREAKPOINT_EN
    logic bp_hit_reg;
    logic bp_mask_reg;

    // The first enabled cycle after IDLE is masked so a resume executes the
    // instruction that tripped the breakpoint instead of re-stopping on it.
    assign bp_stop = (state_reg == ST_RUN) && bus.bp_valid && !bp_mask_reg &&
                     (bus.pc_IF == bus.bp_pc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bp_hit_reg  <= 1'b0;
            bp_mask_reg <= 1'b0;
        end else begin
            bp_mask_reg <= (state_reg == ST_IDLE);
            if (bp_stop) begin
                bp_hit_reg <= 1'b1;
            end else if (cmd_accept) begin
                bp_hit_reg <= 1'b0;
            end
        end
    end

    assign bus.bp_hit = bp_hit_reg;
`else
    logic unused_pc_if;
    assign unused_pc_if = ^bus.pc_IF;
    assign bp_stop      = 1'b0;
`endif

    // A breakpoint freezes the cycle entirely, so the HALT compare is only
    // meaningful when the instruction is actually allowed to advance.
    assign halt_hit    = run_like && !bp_stop && (bus.instruction_IF == HALT_OPCODE);
    assign pipe_en_int = (run_like && !bp_stop) || (state_reg == ST_DRAIN);

    always_comb begin
        state_next     = state_reg;
        drain_cnt_next = drain_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_accept) begin
                    case (bus.cmd)
                        CMD_RUN:   state_next = ST_RUN;
                        CMD_STEP:  state_next = ST_STEP;
                        CMD_CLEAR: state_next = ST_FLUSH;
                        default:   state_next = ST_IDLE;
                    endcase
                end
            end
            ST_RUN: begin
                // HALT outranks STOP/CLEAR in the same cycle; the command is
                // still handshaken (cmd_ready=1) but dropped.
                if (bp_stop) begin
                    state_next = ST_IDLE;
                end else if (halt_hit) begin
                    state_next     = ST_DRAIN;
                    drain_cnt_next = DRAIN_LOAD;
                end else if (cmd_accept && (bus.cmd == CMD_STOP)) begin
                    state_next = ST_IDLE;
                end else if (cmd_accept && (bus.cmd == CMD_CLEAR)) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_STEP: begin
                if (halt_hit) begin
                    state_next     = ST_DRAIN;
                    drain_cnt_next = DRAIN_LOAD;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_reg == '0) begin
                    state_next = ST_HALTED;
                end else begin
                    drain_cnt_next = drain_cnt_reg - DRAIN_W'(1);
                end
            end
            ST_HALTED: begin
                if (cmd_accept && (bus.cmd == CMD_CLEAR)) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            drain_cnt_reg  <= '0;
            done_pulse_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            drain_cnt_reg  <= drain_cnt_next;
            done_pulse_reg <= (state_reg == ST_DRAIN) && (state_next == ST_HALTED);
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (state_reg == ST_FLUSH),
        .en    (pipe_en_int),
        .count (count_int)
    );

    assign bus.cmd_ready    = cmd_ready_int;
    assign bus.pipe_en      = pipe_en_int;
    assign bus.fetch_bubble = halt_hit || (state_reg == ST_DRAIN);
    assign bus.pc_hold      = halt_hit || (state_reg == ST_DRAIN);
    assign bus.pipe_flush   = (state_reg == ST_FLUSH);
    assign bus.busy         = run_like || (state_reg == ST_DRAIN) || (state_reg == ST_FLUSH);
    assign bus.halted       = (state_reg == ST_HALTED);
    assign bus.done_pulse   = done_pulse_reg;
    assign bus.cycle_count  = count_int;
endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_exec_ctrl
// Self-checking bench for pipeline_exec_ctrl. A tiny fetch-stage stand-in
// advances a PC on pipe_en && !pc_hold and presents HALT at halt_pc.
// Expected values are queued as each stimulus is applied; observations are
// queued as the DUT responds and each scenario drains both queues in order.
// Define PIPE_CTRL_BREAKPOINT_EN for both RTL and bench to cover breakpoints.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipeline_exec_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int          CNT_W     = 32;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] ADDI_WORD = 32'h2108_0001;
    localparam logic [31:0] FAR_PC    = 32'h0000_1000;

    logic clk = 1'b0;
    logic reset;

    pipeline_exec_ctrl_if #(.CNT_W(CNT_W)) bus();

    pipeline_exec_ctrl #(
        .CNT_W        (CNT_W),
        .HALT_OPCODE  (HALT_WORD),
        .DRAIN_CYCLES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Fetch-stage stand-in
    logic [31:0] pc_model;
    logic [31:0] halt_pc;
    always @(posedge clk or negedge reset) begin
        if (!reset)                            pc_model <= 32'd0;
        else if (bus.pipe_flush)               pc_model <= 32'd0;
        else if (bus.pipe_en && !bus.pc_hold)  pc_model <= pc_model + 32'd4;
    end
    assign bus.pc_IF          = pc_model;
    assign bus.instruction_IF = (pc_model == halt_pc) ? HALT_WORD : ADDI_WORD;

    // Scoreboard
    string       tag_q[$];
    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic expect_val(input string tag, input logic [63:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic observe(input logic [63:0] v);
        obs_q.push_back(v);
    endtask

    // Drive one command cycle at the falling edge, then settle for sampling.
    task automatic tick(input logic v, input logic [1:0] c);
        @(negedge clk);
        bus.cmd_valid = v;
        bus.cmd       = c;
        #1;
    endtask

    task automatic test_reset();
        string tag; logic [63:0] got, want;
        reset = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd = CMD_RUN;
        halt_pc = FAR_PC;
        expect_val("rst.cmd_ready", 1); expect_val("rst.pipe_en", 0);
        expect_val("rst.pc_hold", 0);   expect_val("rst.fetch_bubble", 0);
        expect_val("rst.pipe_flush", 0); expect_val("rst.busy", 0);
        expect_val("rst.halted", 0);    expect_val("rst.done_pulse", 0);
        expect_val("rst.cycle_count", 0);
        repeat (2) @(negedge clk);
        #1;
        observe(bus.cmd_ready); observe(bus.pipe_en); observe(bus.pc_hold);
        observe(bus.fetch_bubble); observe(bus.pipe_flush); observe(bus.busy);
        observe(bus.halted); observe(bus.done_pulse); observe(64'(bus.cycle_count));
        while (obs_q.size() > 0) begin
            got = obs_q.pop_front(); n_vec++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL sb_underflow: got %0d, want nothing", got); end
            else begin
                want = exp_q.pop_front(); tag = tag_q.pop_front();
                $display("[reset] %s got=%0d want=%0d", tag, got, want);
                if (got !== want) begin n_err++; $display("FAIL %s: got %0d, want %0d", tag, got, want); end
            end
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_run_halt();
        string tag; logic [63:0] got, want;
        int first_bub = 0, bub = 0, hold = 0, en = 0, dn = 0, dn_cyc = 0;
        halt_pc = 32'd8;
        tick(1'b1, CMD_RUN);
        expect_val("halt.first_bubble_cycle", 3); expect_val("halt.bubble_cycles", 5);
        expect_val("halt.pc_hold_cycles", 5);     expect_val("halt.pipe_en_cycles", 7);
        expect_val("halt.done_pulses", 1);        expect_val("halt.done_cycle", 8);
        expect_val("halt.halted", 1);             expect_val("halt.cycle_count", 7);
        for (int i = 1; i <= 20; i++) begin
            tick(1'b0, CMD_RUN);
            if (bus.fetch_bubble) begin bub++; if (first_bub == 0) first_bub = i; end
            if (bus.pc_hold) hold++;
            if (bus.pipe_en) en++;
            if (bus.done_pulse) begin dn++; dn_cyc = i; end
        end
        observe(first_bub); observe(bub); observe(hold); observe(en);
        observe(dn); observe(dn_cyc); observe(bus.halted); observe(64'(bus.cycle_count));
        while (obs_q.size() > 0) begin
            got = obs_q.pop_front(); n_vec++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL sb_underflow: got %0d, want nothing", got); end
            else begin
                want = exp_q.pop_front(); tag = tag_q.pop_front();
                $display("[run_halt] %s got=%0d want=%0d", tag, got, want);
                if (got !== want) begin n_err++; $display("FAIL %s: got %0d, want %0d", tag, got, want); end
            end
        end
    endtask

    task automatic test_halted_clear();
        string tag; logic [63:0] got, want;
        halt_pc = FAR_PC;
        tick(1'b1, CMD_RUN);
        expect_val("hc.run.cmd_ready", 1); expect_val("hc.run.pipe_en", 0);
        observe(bus.cmd_ready); observe(bus.pipe_en);
        tick(1'b1, CMD_STEP);
        expect_val("hc.step.pipe_en", 0); expect_val("hc.step.halted", 1);
        observe(bus.pipe_en); observe(bus.halted);
        tick(1'b0, CMD_RUN);
        expect_val("hc.idle.pipe_en", 0); expect_val("hc.idle.cycle_count", 7);
        observe(bus.pipe_en); observe(64'(bus.cycle_count));
        tick(1'b1, CMD_CLEAR);
        expect_val("hc.clear.cmd_ready", 1); expect_val("hc.clear.halted", 1);
        observe(bus.cmd_ready); observe(bus.halted);
        tick(1'b0, CMD_RUN);
        expect_val("hc.flush.pipe_flush", 1); expect_val("hc.flush.pipe_en", 0);
        expect_val("hc.flush.busy", 1);       expect_val("hc.flush.cmd_ready", 0);
        observe(bus.pipe_flush); observe(bus.pipe_en); observe(bus.busy); observe(bus.cmd_ready);
        tick(1'b0, CMD_RUN);
        expect_val("hc.after.pipe_flush", 0); expect_val("hc.after.cycle_count", 0);
        expect_val("hc.after.halted", 0);     expect_val("hc.after.busy", 0);
        expect_val("hc.after.cmd_ready", 1);  expect_val("hc.after.pc", 0);
        observe(bus.pipe_flush); observe(64'(bus.cycle_count)); observe(bus.halted);
        observe(bus.busy); observe(bus.cmd_ready); observe(pc_model);
        while (obs_q.size() > 0) begin
            got = obs_q.pop_front(); n_vec++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL sb_underflow: got %0d, want nothing", got); end
            else begin
                want = exp_q.pop_front(); tag = tag_q.pop_front();
                $display("[halted_clear] %s got=%0d want=%0d", tag, got, want);
                if (got !== want) begin n_err++; $display("FAIL %s: got %0d, want %0d", tag, got, want); end
            end
        end
    endtask

    task automatic test_step();
        string tag; logic [63:0] got, want;
        int pulses = 0, ready_low = 0;
        halt_pc = FAR_PC;
        expect_val("step.pipe_en_pulses", 3); expect_val("step.ready_low_on_step", 3);
        expect_val("step.cycle_count", 3);    expect_val("step.pc", 12);
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, CMD_STEP);
            if (bus.pipe_en) pulses++;
            tick(1'b0, CMD_STEP);
            if (bus.pipe_en) pulses++;
            if (bus.pipe_en && !bus.cmd_ready) ready_low++;
            tick(1'b0, CMD_STEP);
            if (bus.pipe_en) pulses++;
        end
        observe(pulses); observe(ready_low); observe(64'(bus.cycle_count)); observe(pc_model);
        while (obs_q.size() > 0) begin
            got = obs_q.pop_front(); n_vec++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL sb_underflow: got %0d, want nothing", got); end
            else begin
                want = exp_q.pop_front(); tag = tag_q.pop_front();
                $display("[step] %s got=%0d want=%0d", tag, got, want);
                if (got !== want) begin n_err++; $display("FAIL %s: got %0d, want %0d", tag, got, want); end
            end
        end
    endtask

    task automatic test_stop_resume();
        string tag; logic [63:0] got, want;
        int en = 0, gap = 0, flushes = 0;
        halt_pc = FAR_PC;
        tick(1'b1, CMD_CLEAR);
        tick(1'b0, CMD_RUN);
        tick(1'b1, CMD_RUN);
        expect_val("sr.run_cycles", 5);      expect_val("sr.gap_pipe_en_low", 2);
        expect_val("sr.count_at_gap", 5);    expect_val("sr.pc_at_gap", 20);
        expect_val("sr.count_after_resume", 6); expect_val("sr.pc_after_resume", 24);
        expect_val("sr.flushes", 0);
        for (int i = 1; i <= 5; i++) begin
            tick(i == 5, CMD_STOP);
            if (bus.pipe_en) en++;
        end
        tick(1'b0, CMD_RUN);
        if (!bus.pipe_en) gap++;
        if (bus.pipe_flush) flushes++;
        observe(en); 
        tick(1'b1, CMD_RUN);
        if (!bus.pipe_en) gap++;
        if (bus.pipe_flush) flushes++;
        observe(gap); observe(64'(bus.cycle_count)); observe(pc_model);
        tick(1'b0, CMD_RUN);
        if (bus.pipe_flush) flushes++;
        tick(1'b1, CMD_STOP);
        if (bus.pipe_flush) flushes++;
        observe(64'(bus.cycle_count)); observe(pc_model); observe(flushes);
        tick(1'b0, CMD_RUN);
        while (obs_q.size() > 0) begin
            got = obs_q.pop_front(); n_vec++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL sb_underflow: got %0d, want nothing", got); end
            else begin
                want = exp_q.pop_front(); tag = tag_q.pop_front();
                $display("[stop_resume] %s got=%0d want=%0d", tag, got, want);
                if (got !== want) begin n_err++; $display("FAIL %s: got %0d, want %0d", tag, got, want); end
            end
        end
    endtask

    task automatic test_halt_beats_stop();
        string tag; logic [63:0] got, want;
        int drain_ok = 0;
        tick(1'b1, CMD_CLEAR);
        tick(1'b0, CMD_RUN);
        halt_pc = 32'd8;
        tick(1'b1, CMD_RUN);
        tick(1'b0, CMD_RUN);
        tick(1'b0, CMD_RUN);
        tick(1'b1, CMD_STOP);
        expect_val("hbs.fetch_bubble", 1); expect_val("hbs.pc_hold", 1);
        expect_val("hbs.pipe_en", 1);      expect_val("hbs.cmd_ready", 1);
        expect_val("hbs.drain_cycles", 4); expect_val("hbs.halted", 1);
        expect_val("hbs.done_pulse", 1);   expect_val("hbs.cycle_count", 7);
        observe(bus.fetch_bubble); observe(bus.pc_hold); observe(bus.pipe_en); observe(bus.cmd_ready);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, CMD_RUN);
            if (bus.pipe_en && bus.fetch_bubble && !bus.cmd_ready && bus.busy) drain_ok++;
        end
        tick(1'b0, CMD_RUN);
        observe(drain_ok); observe(bus.halted); observe(bus.done_pulse); observe(64'(bus.cycle_count));
        while (obs_q.size() > 0) begin
            got = obs_q.pop_front(); n_vec++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL sb_underflow: got %0d, want nothing", got); end
            else begin
                want = exp_q.pop_front(); tag = tag_q.pop_front();
                $display("[halt_beats_stop] %s got=%0d want=%0d", tag, got, want);
                if (got !== want) begin n_err++; $display("FAIL %s: got %0d, want %0d", tag, got, want); end
            end
        end
    endtask

    task automatic test_reset_in_drain();
        string tag; logic [63:0] got, want;
        int dn = 0, hl = 0, en = 0;
        tick(1'b1, CMD_CLEAR);
        tick(1'b0, CMD_RUN);
        halt_pc = 32'd8;
        tick(1'b1, CMD_RUN);
        repeat (5) tick(1'b0, CMD_RUN);
        expect_val("rd.drain2.busy", 1); expect_val("rd.drain2.fetch_bubble", 1);
        observe(bus.busy); observe(bus.fetch_bubble);
        #2 reset = 1'b0;
        #1;
        expect_val("rd.async.pipe_en", 0);   expect_val("rd.async.fetch_bubble", 0);
        expect_val("rd.async.pc_hold", 0);   expect_val("rd.async.busy", 0);
        expect_val("rd.async.cmd_ready", 1); expect_val("rd.async.cycle_count", 0);
        observe(bus.pipe_en); observe(bus.fetch_bubble); observe(bus.pc_hold);
        observe(bus.busy); observe(bus.cmd_ready); observe(64'(bus.cycle_count));
        @(negedge clk);
        reset = 1'b1;
        expect_val("rd.after.done_pulses", 0); expect_val("rd.after.halted_cycles", 0);
        expect_val("rd.after.pipe_en_cycles", 0);
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, CMD_RUN);
            if (bus.done_pulse) dn++;
            if (bus.halted) hl++;
            if (bus.pipe_en) en++;
        end
        observe(dn); observe(hl); observe(en);
        halt_pc = FAR_PC;
        while (obs_q.size() > 0) begin
            got = obs_q.pop_front(); n_vec++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL sb_underflow: got %0d, want nothing", got); end
            else begin
                want = exp_q.pop_front(); tag = tag_q.pop_front();
                $display("[reset_in_drain] %s got=%0d want=%0d", tag, got, want);
                if (got !== want) begin n_err++; $display("FAIL %s: got %0d, want %0d", tag, got, want); end
            end
        end
    endtask

`ifdef PIPE_CTRL_BREAKPOINT_EN
    initial begin
        bus.bp_valid = 1'b0;
        bus.bp_pc    = 32'd0;
    end

    task automatic test_breakpoint();
        string tag; logic [63:0] got, want;
        int en = 0;
        halt_pc = FAR_PC;
        bus.bp_valid = 1'b1;
        bus.bp_pc    = 32'd12;
        tick(1'b1, CMD_RUN);
        expect_val("bp.run_cycles", 3); expect_val("bp.stop_pc", 12);
        expect_val("bp.hit", 1);        expect_val("bp.busy", 0);
        expect_val("bp.sticky", 1);     expect_val("bp.cleared", 0);
        expect_val("bp.resume.pipe_en", 1); expect_val("bp.resume.pc", 16);
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, CMD_RUN);
            if (!bus.pipe_en) break;
            en++;
        end
        observe(en); observe(pc_model);
        tick(1'b0, CMD_RUN);
        observe(bus.bp_hit); observe(bus.busy);
        tick(1'b1, CMD_RUN);
        observe(bus.bp_hit);
        tick(1'b0, CMD_RUN);
        observe(bus.bp_hit); observe(bus.pipe_en);
        tick(1'b1, CMD_STOP);
        observe(pc_model);
        tick(1'b0, CMD_RUN);
        bus.bp_valid = 1'b0;
        while (obs_q.size() > 0) begin
            got = obs_q.pop_front(); n_vec++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL sb_underflow: got %0d, want nothing", got); end
            else begin
                want = exp_q.pop_front(); tag = tag_q.pop_front();
                $display("[breakpoint] %s got=%0d want=%0d", tag, got, want);
                if (got !== want) begin n_err++; $display("FAIL %s: got %0d, want %0d", tag, got, want); end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_run_halt();
        test_halted_clear();
        test_step();
        test_stop_resume();
        test_halt_beats_stop();
        test_reset_in_drain();
`ifdef PIPE_CTRL_BREAKPOINT_EN
        test_breakpoint();
`endif
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_leftover: got %0d unmatched, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
